// File: rtl/scanner_source_arbiter.sv
// Light-source arbiter for scan (req0) and calibration (req1) exposures.
// Define SCANNER_ARB_ROUND_ROBIN_EN for round-robin; default is fixed req0 priority.
module scanner_source_arbiter #(
  parameter int EXP_W        = 8,
  parameter int RAMP_TIMEOUT = 8,
  parameter int MIN_OFF      = 4,
  parameter int MAX_ERR      = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       req,
  input  logic [EXP_W-1:0] exp_len0,
  input  logic [EXP_W-1:0] exp_len1,
  input  logic             env_ok,
  input  logic             source_on,
  input  logic             fault_clr,
  output logic             cmd_source_active,
  output logic [1:0]       gnt,
  output logic [1:0]       done,
  output logic             err,
  output logic             busy,
  output logic             fault
);

  localparam int RW = $clog2(RAMP_TIMEOUT + 1);
  localparam int CW = $clog2(MIN_OFF + 1);
  localparam int EW = $clog2(MAX_ERR + 1);

  typedef enum logic [2:0] {
    IDLE, RAMP, EXPOSE, COOL, FAULT
  } state_t;

  state_t           state;
  logic             win;
  logic             pick;
  logic [EXP_W-1:0] sel_len;
  logic [EXP_W-1:0] exp_cnt;
  logic [RW-1:0]    ramp_cnt;
  logic [CW-1:0]    cool_cnt;
  logic [EW-1:0]    err_cnt;
  logic [EW-1:0]    err_nxt;
  logic             active;
  logic             cancel;
  logic             abort_ev;
  logic             complete;
  logic             finish;

`ifdef SCANNER_ARB_ROUND_ROBIN_EN
  logic ptr;
  assign pick = (req == 2'b11) ? ptr : ~req[0];
`else
  assign pick = ~req[0];
`endif

  assign sel_len = pick ? exp_len1 : exp_len0;
  assign err_nxt = err_cnt + EW'(1);
  assign active  = (state == RAMP) || (state == EXPOSE);
  assign cancel  = active && !req[win];

  // Expiry beats a same-cycle source loss.
  assign complete = (state == EXPOSE) && !cancel &&
                    (exp_cnt == EXP_W'(1));

  // A source rise on the timeout cycle still counts as success.
  assign abort_ev = !cancel && (
    ((state == RAMP) && (!env_ok ||
      (!source_on && ramp_cnt == RW'(RAMP_TIMEOUT - 1)))) ||
    ((state == EXPOSE) && (exp_cnt != EXP_W'(1)) &&
      (!source_on || !env_ok)));

  assign finish = cancel || complete || abort_ev;

  always_ff @(posedge clk) begin
    if (reset) begin
      state             <= IDLE;
      cmd_source_active <= 1'b0;
      gnt               <= 2'b00;
      done              <= 2'b00;
      err               <= 1'b0;
      busy              <= 1'b0;
      fault             <= 1'b0;
      win               <= 1'b0;
      exp_cnt           <= '0;
      ramp_cnt          <= '0;
      cool_cnt          <= '0;
      err_cnt           <= '0;
`ifdef SCANNER_ARB_ROUND_ROBIN_EN
      ptr               <= 1'b0;
`endif
    end else begin
      done <= 2'b00;
      err  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (env_ok && |req) begin
            win               <= pick;
            gnt               <= pick ? 2'b10 : 2'b01;
            cmd_source_active <= 1'b1;
            busy              <= 1'b1;
            ramp_cnt          <= '0;
            exp_cnt           <= (sel_len == '0) ? EXP_W'(1)
                                                 : sel_len;
            state             <= RAMP;
          end
        end
        RAMP: begin
          if (!finish) begin
            if (source_on) state <= EXPOSE;
            else ramp_cnt <= ramp_cnt + RW'(1);
          end
        end
        EXPOSE: begin
          if (!finish) exp_cnt <= exp_cnt - EXP_W'(1);
        end
        COOL: begin
          if (cool_cnt == CW'(MIN_OFF - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            cool_cnt <= cool_cnt + CW'(1);
          end
        end
        FAULT: begin
          if (fault_clr) begin
            fault   <= 1'b0;
            err_cnt <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (finish) begin
        cmd_source_active <= 1'b0;
        gnt               <= 2'b00;
        cool_cnt          <= '0;
        state             <= COOL;
`ifdef SCANNER_ARB_ROUND_ROBIN_EN
        ptr               <= ~win;
`endif
        if (complete) begin
          done    <= win ? 2'b10 : 2'b01;
          err_cnt <= '0;
        end
        if (abort_ev) begin
          done    <= win ? 2'b10 : 2'b01;
          err     <= 1'b1;
          err_cnt <= err_nxt;
          if (err_nxt == EW'(MAX_ERR)) begin
            state <= FAULT;
            fault <= 1'b1;
            busy  <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: doc/scanner_source_arbiter.md
Name: scanner_source_arbiter

Overview:
- Shares the scanner light source between two requesters: req0 is the scan path, req1 is the calibration/alignment path.
- Sits between the requesters and the light-source/environment control block. Drives that block's cmd_source_active and monitors its source_on and env_ok.
- Sequences each exposure as grant -> ramp-up wait -> timed exposure -> minimum off-time.
- Detects ramp timeouts and source/environment loss, and latches a fault after repeated consecutive errors.

Parameters:
- EXP_W, 8, width of exposure-length inputs (cycles).
- RAMP_TIMEOUT, 8, max cycles in RAMP waiting for source_on before abort.
- MIN_OFF, 4, cycles cmd_source_active held low in COOL before next grant.
- MAX_ERR, 3, consecutive error count that latches fault.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  request per requester; held high until done.
- exp_len0  in  EXP_W  exposure length for requester 0; sampled at grant.
- exp_len1  in  EXP_W  exposure length for requester 1; sampled at grant.
- env_ok  in  1  environment-ready flag from source control.
- source_on  in  1  actual light-source state from source control.
- fault_clr  in  1  single-cycle pulse; clears latched fault.
- cmd_source_active  out  1  light-source on command (registered).
- gnt  out  2  one-hot grant, held from grant through end of exposure.
- done  out  2  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with done when the exposure aborted.
- busy  out  1  high in any state other than IDLE and FAULT.
- fault  out  1  latched fault flag.

Behaviour:
- Clocking and reset: all state changes on posedge clk only. Reset is synchronous, active-high, and wins over every other input, including mid-exposure.
- Reset values: state=IDLE; cmd_source_active, gnt, done, err, busy, fault all 0; error counter 0; priority pointer 0.
- IDLE:
  - If env_ok=1 and any req bit is high, select the winner (fixed priority, req0 > req1, unless ROUND_ROBIN_EN).
  - Latch the winner's exp_len; a value of 0 is treated as 1.
  - On the next edge: gnt[winner]=1, cmd_source_active=1, clear ramp timer, go RAMP.
  - If env_ok=0, no grant is issued and requests wait.
- RAMP:
  - Timer increments each cycle.
  - source_on=1 sampled -> go EXPOSE and load the exposure counter.
  - Timer reaching RAMP_TIMEOUT with source_on still 0 -> abort.
  - env_ok=0 -> abort.
- EXPOSE:
  - cmd_source_active stays high for exactly exp_len cycles in EXPOSE.
  - Counter expiry -> normal completion.
  - source_on=0 or env_ok=0 sampled before expiry -> abort.
- Normal completion (single edge):
  - cmd_source_active=0, gnt=0, done[winner] pulses for 1 cycle with err=0.
  - Error counter cleared; go COOL.
- Abort (single edge):
  - cmd_source_active=0, gnt=0, done[winner]=1 and err=1 for 1 cycle.
  - Error counter increments.
  - If the incremented count equals MAX_ERR: go FAULT, fault=1. Otherwise go COOL.
- Cancel:
  - The granted req dropping in RAMP/EXPOSE -> cmd/gnt drop, no done, no err, counter unchanged, go COOL.
- COOL:
  - cmd_source_active=0 for exactly MIN_OFF cycles, then IDLE.
  - Requests arriving in COOL are held off until IDLE.
- FAULT:
  - cmd_source_active=0, no grants, busy=0.
  - fault_clr -> fault=0, error counter 0, go IDLE.
- Simultaneous events:
  - Counter expiry and source_on fall on the same cycle count as completion.
  - Timeout and source_on rise on the same cycle count as success (go EXPOSE).
  - fault_clr outside FAULT is ignored.
- Latency with the 1-cycle source model: req -> gnt/cmd is 1 cycle; cmd -> EXPOSE entry is 2 cycles.

Optional Feature:
- Macro: SCANNER_ARB_ROUND_ROBIN_EN.
- Defined: two-way round-robin. After each grant (complete, abort or cancel), the priority pointer moves to the other requester, so on simultaneous requests the one not served last wins.
- Undefined: fixed priority, req0 always beats req1; no pointer register.

Test Plan:
- Basic exposure (env_ok=1, req0=1, exp_len0=5, source_on lags cmd by 1 cycle): gnt0 1 cycle after req; cmd high 7 cycles total; done0=1 with err=0; busy low 4 cycles after done.
- Arbitration (req0 and req1 asserted together, exp_len=3 each, macro off): requester 0 served first, requester 1 granted after COOL; with the macro on and requester 0 served last, requester 1 wins the next tie.
- Ramp timeout (source_on tied 0): done with err=1 after 8 RAMP cycles; cmd drops the same edge; repeated 3 times consecutively -> fault=1, later req ignored; fault_clr -> IDLE, next req granted.
- Source loss (source_on forced 0 at cycle 2 of a 10-cycle exposure): abort next edge, err=1; a following successful exposure clears the error counter.
- env_ok gating and cancel: with env_ok=0, req held 20 cycles gives no gnt, cmd=0; raising env_ok grants next edge. Dropping req mid-EXPOSE gives cmd=0 with no done/err.
- Reset mid-EXPOSE: every output is 0 the cycle after reset; no done pulse.
